// File: rtl/fp_sqrt_controller.sv
// fp_sqrt_controller: IEEE-754 single-precision square-root sequencer around an
// external fixed-point mantissa core (Y[22:0] in, 1.23 result out).
// Optional feature macro: FP_SQRT_FLAGS_EN adds the flags[1:0] = {invalid, flushed} port.
module fp_sqrt_controller #(
  parameter int          CORE_LATENCY = 1,
  parameter logic [23:0] SQRT2_CONST  = 24'hB504F3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [22:0] mant_y,
  input  logic [23:0] core_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
`ifdef FP_SQRT_FLAGS_EN
  ,
  output logic [1:0]  flags
`endif
);

  localparam int CW = (CORE_LATENCY < 2) ? 1 : $clog2(CORE_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SCALE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          odd_q;
  logic [7:0]    er_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [31:0]   out_data_q;
  logic [22:0]   mant_y_q;

  // Operand fields
  logic          op_s;
  logic [7:0]    op_e;
  logic [22:0]   op_f;

  // Special-case screening and result exponent
  logic          is_nan_d;
  logic          is_neg_d;
  logic          is_zexp_d;
  logic          is_inf_d;
  logic          is_special_d;
  logic [31:0]   special_data_d;
  logic [8:0]    er_sum_d;
  logic [7:0]    er_d;

  // Output-side mantissa scaling
  logic [47:0]   prod_d;
  logic [22:0]   mant_res_d;

  assign op_s = in_data[31];
  assign op_e = in_data[30:23];
  assign op_f = in_data[22:0];

  // Classify the operand in priority order and pick the special result
  always_comb begin
    is_nan_d       = (op_e == 8'hFF) && (op_f != 23'd0);
    is_neg_d       = op_s && (in_data != 32'h8000_0000);
    is_zexp_d      = (op_e == 8'h00);
    is_inf_d       = (op_e == 8'hFF);
    is_special_d   = is_nan_d || is_neg_d || is_zexp_d || is_inf_d;
    special_data_d = 32'h7F80_0000;
    if (is_nan_d || is_neg_d) begin
      special_data_d = 32'h7FC0_0000;
    end else if (is_zexp_d) begin
      special_data_d = {op_s, 31'd0};
    end
    // Halving the biased exponent: the bias correction depends on exponent parity
    er_sum_d = {1'b0, op_e} + (op_e[0] ? 9'd127 : 9'd126);
    er_d     = 8'(er_sum_d >> 1);
  end

  // Odd unbiased exponents fold a factor of sqrt(2) into the mantissa (truncated)
  always_comb begin
    prod_d     = {24'd0, core_result} * {24'd0, SQRT2_CONST};
    mant_res_d = odd_q ? 23'(prod_d >> 23) : 23'(core_result);
  end

`ifdef FP_SQRT_FLAGS_EN
  logic [1:0] flags_q;
  logic [1:0] special_flags_d;

  // Status flags for the special-case path
  always_comb begin
    special_flags_d = 2'b00;
    if (is_nan_d || is_neg_d) begin
      special_flags_d = 2'b10;
    end else if (is_zexp_d && (op_f != 23'd0)) begin
      special_flags_d = 2'b01;
    end
  end

  // Flags follow out_data and clear on each accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 2'b00;
    end else if (state_q == S_IDLE && in_valid && in_ready_q) begin
      flags_q <= is_special_d ? special_flags_d : 2'b00;
    end else if (state_q == S_SCALE) begin
      flags_q <= 2'b00;
    end
  end

  assign flags = flags_q;
`endif

  // Sequencer: accept, wait on the core, scale, then hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      odd_q       <= 1'b0;
      er_q        <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      mant_y_q    <= 23'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (is_special_d) begin
              out_data_q  <= special_data_d;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              mant_y_q <= op_f;
              odd_q    <= ~op_e[0];
              er_q     <= er_d;
              cnt_q    <= CW'(CORE_LATENCY);
              state_q  <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= S_SCALE;
          end
        end
        S_SCALE: begin
          out_data_q  <= {1'b0, er_q, mant_res_d};
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign mant_y    = mant_y_q;

endmodule
